// File: rtl/cyber_player_pkg.sv
// Shared types and constants for the cyber_player automated opponent.
package cyber_player_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    COOL = 1'b1
  } state_e;

  localparam int unsigned LFSR_WIDTH   = 10;
  localparam int unsigned LFSR_TAP_HI  = 9;
  localparam int unsigned LFSR_TAP_LO  = 6;
  localparam logic [9:0]  DEFAULT_SEED = 10'h001;

endpackage

// File: rtl/lfsr10.sv
// Fibonacci LFSR (x^10+x^7+1), shifts left, advances only when enabled.
// Optional lockup guard under LFSR_LOCKUP_GUARD_EN reseeds from the all-zero state.
module lfsr10
  import cyber_player_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  logic             fb_c;
  logic [WIDTH-1:0] q_next_c;

  // Next state: shift in feedback, or reseed when stuck at zero if guarded
  always_comb begin
    fb_c     = q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO];
    q_next_c = {q[WIDTH-2:0], fb_c};
`ifdef LFSR_LOCKUP_GUARD_EN
    if (q == '0) begin
      q_next_c = (SEED == '0) ? WIDTH'(DEFAULT_SEED) : SEED;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (enable) begin
      q <= q_next_c;
    end
  end

endmodule

// File: rtl/cyber_player.sv
// Automated button-game opponent: registered threshold compare against an LFSR
// operand, turned into rate-limited press pulses. Optional macro: LFSR_LOCKUP_GUARD_EN.
module cyber_player
  import cyber_player_pkg::*;
#(
  parameter int unsigned      WIDTH    = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
  parameter int unsigned      COOLDOWN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] rand_val,
  output logic             cmp_gt,
  output logic             press
);

  localparam int unsigned CNT_W = $clog2(COOLDOWN + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d;
  logic [WIDTH:0]   diff_c;
  logic             gt_c;

  lfsr10 #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .q      (rand_val)
  );

  // A borrow out of rand_val - threshold means threshold is strictly greater
  always_comb begin
    diff_c = {1'b0, rand_val} - {1'b0, threshold};
    gt_c   = diff_c[WIDTH];
  end

  // Press FSM next state: fire from IDLE, then hold off for COOLDOWN cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmp_gt) begin
            press_d = 1'b1;
            cnt_d   = CNT_W'(COOLDOWN);
            state_d = COOL;
          end
        end
        COOL: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press   <= 1'b0;
      cmp_gt  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press   <= press_d;
      cmp_gt  <= gt_c;
    end
  end

endmodule

// File: tb/tb_cyber_player.sv
// Directed self-checking bench for cyber_player (default and zero-seed instances).
module tb_cyber_player;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       enable;
  logic [9:0] threshold;
  logic [9:0] rand_val;
  logic       cmp_gt;
  logic       press;

  logic       z_enable;
  logic [9:0] z_threshold;
  logic [9:0] z_rand_val;
  logic       z_cmp_gt;
  logic       z_press;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cyber_player #(
    .WIDTH    (10),
    .SEED     (10'h001),
    .COOLDOWN (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .threshold (threshold),
    .rand_val  (rand_val),
    .cmp_gt    (cmp_gt),
    .press     (press)
  );

  cyber_player #(
    .WIDTH    (10),
    .SEED     (10'h000),
    .COOLDOWN (4)
  ) dut_z (
    .clk       (clk),
    .reset     (reset),
    .enable    (z_enable),
    .threshold (z_threshold),
    .rand_val  (z_rand_val),
    .cmp_gt    (z_cmp_gt),
    .press     (z_press)
  );

  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] exp_seq [7];
    exp_seq = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};
    enable = 1'b1; threshold = 10'h000;
    z_enable = 1'b0; z_threshold = 10'h000;
    #2;
    reset = 1'b0;
    tick();
    tick();
    n_tests++;
    if (rand_val !== 10'h001 || cmp_gt !== 1'b0 || press !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rand=%h cmp=%b press=%b expected 001 0 0", rand_val, cmp_gt, press);
    end
    n_tests++;
    if (z_rand_val !== 10'h000 || z_press !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_z: got rand=%h press=%b expected 000 0", z_rand_val, z_press);
    end
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++;
      if (rand_val !== exp_seq[i] || press !== 1'b0 || cmp_gt !== 1'b0) begin
        n_fail++;
        $display("FAIL lfsr_seq[%0d]: got rand=%h press=%b cmp=%b expected %h 0 0",
                 i, rand_val, press, cmp_gt, exp_seq[i]);
      end
    end
  endtask

  task automatic test_max_threshold();
    logic exp_p;
    threshold = 10'h3FF; enable = 1'b1;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick();
      exp_p = (e >= 2) && (((e - 2) % 5) == 0);
      n_tests++;
      if (press !== exp_p) begin
        n_fail++;
        $display("FAIL press_spacing edge %0d: got %b expected %b", e, press, exp_p);
      end
    end
  endtask

  task automatic test_enable_drop();
    threshold = 10'h3FF; enable = 1'b1;
    do_reset();
    repeat (4) tick();
    n_tests++;
    if (rand_val !== 10'h010) begin
      n_fail++;
      $display("FAIL drop_pre: got rand=%h expected 010", rand_val);
    end
    enable = 1'b0;
    tick();
    n_tests++;
    if (rand_val !== 10'h010 || press !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_hold: got rand=%h press=%b expected 010 0", rand_val, press);
    end
    threshold = 10'h010;
    tick();
    n_tests++;
    if (cmp_gt !== 1'b0) begin
      n_fail++;
      $display("FAIL cmp_equal: got %b expected 0", cmp_gt);
    end
    threshold = 10'h011;
    tick();
    n_tests++;
    if (cmp_gt !== 1'b1 || rand_val !== 10'h010) begin
      n_fail++;
      $display("FAIL cmp_above: got cmp=%b rand=%h expected 1 010", cmp_gt, rand_val);
    end
    threshold = 10'h3FF; enable = 1'b1;
    tick();
    n_tests++;
    if (press !== 1'b1 || rand_val !== 10'h020) begin
      n_fail++;
      $display("FAIL reenable_press: got press=%b rand=%h expected 1 020", press, rand_val);
    end
    tick();
    n_tests++;
    if (press !== 1'b0) begin
      n_fail++;
      $display("FAIL reenable_pulse: got press=%b expected 0", press);
    end
  endtask

  task automatic test_async_reset();
    threshold = 10'h3FF; enable = 1'b1;
    do_reset();
    tick();
    tick();
    n_tests++;
    if (press !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_press: got %b expected 1", press);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (press !== 1'b0 || rand_val !== 10'h001 || cmp_gt !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got press=%b rand=%h cmp=%b expected 0 001 0", press, rand_val, cmp_gt);
    end
    tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if (press !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_edge1: got press=%b expected 0", press);
    end
    tick();
    n_tests++;
    if (press !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_edge2: got press=%b expected 1", press);
    end
  endtask

  task automatic test_seed_zero();
    logic exp_p;
    enable = 1'b0;
    z_enable = 1'b1; z_threshold = 10'h005;
    do_reset();
`ifdef LFSR_LOCKUP_GUARD_EN
    tick();
    n_tests++;
    if (z_rand_val !== 10'h001) begin
      n_fail++;
      $display("FAIL guard_reseed: got %h expected 001", z_rand_val);
    end
    tick();
    n_tests++;
    if (z_rand_val !== 10'h002 || z_press !== 1'b1) begin
      n_fail++;
      $display("FAIL guard_step: got rand=%h press=%b expected 002 1", z_rand_val, z_press);
    end
`else
    for (int e = 1; e <= 22; e++) begin
      tick();
      exp_p = (e >= 2) && (((e - 2) % 5) == 0);
      n_tests++;
      if (z_rand_val !== 10'h000 || z_press !== exp_p) begin
        n_fail++;
        $display("FAIL zero_seed edge %0d: got rand=%h press=%b expected 000 %b", e, z_rand_val, z_press, exp_p);
      end
    end
`endif
    z_threshold = 10'h000;
    tick();
    tick();
    n_tests++;
    if (z_cmp_gt !== 1'b0) begin
      n_fail++;
      $display("FAIL thresh_zero_cmp: got %b expected 0", z_cmp_gt);
    end
    z_enable = 1'b0;
  endtask

  task automatic test_period();
    logic [9:0] m;
    int zero_seen, early_ret, model_bad;
    m = 10'h001; zero_seen = 0; early_ret = 0; model_bad = 0;
    threshold = 10'h000; enable = 1'b1;
    do_reset();
    for (int i = 1; i <= 1023; i++) begin
      tick();
      m = lfsr_step(m);
      if (rand_val !== m) model_bad++;
      if (rand_val === 10'h000) zero_seen++;
      if (i < 1023 && rand_val === 10'h001) early_ret++;
    end
    n_tests++;
    if (rand_val !== 10'h001) begin
      n_fail++;
      $display("FAIL period_return: got %h expected 001", rand_val);
    end
    n_tests++;
    if (zero_seen != 0 || early_ret != 0) begin
      n_fail++;
      $display("FAIL period_states: got zeros=%0d early=%0d expected 0 0", zero_seen, early_ret);
    end
    n_tests++;
    if (model_bad != 0) begin
      n_fail++;
      $display("FAIL period_sequence: got %0d deviating steps expected 0", model_bad);
    end
  endtask

  initial begin
    test_reset();
    test_max_threshold();
    test_enable_drop();
    test_async_reset();
    test_seed_zero();
    test_period();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
